// File: rtl/my_dmux_pkg.sv
// Shared definitions for the 4-way stream demultiplexer: default sizes,
// channel indices and the destination-select type.
package my_dmux_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 16;

  typedef logic [1:0] sel_t;

  localparam sel_t CH_A = 2'd0;
  localparam sel_t CH_B = 2'd1;
  localparam sel_t CH_C = 2'd2;
  localparam sel_t CH_D = 2'd3;

  // One-hot channel mask for a destination select.
  function automatic logic [3:0] sel_onehot(input sel_t s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/my_stream_fifo.sv
// Small synchronous FIFO for one output channel. Push is ignored while
// full and pop is ignored while empty. The head word reads 0 when the
// FIFO is empty.
module my_stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [OW-1:0]    occ;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (occ == OW'(DEPTH));
  assign empty   = (occ == '0);
  assign head    = empty ? '0 : mem[rptr];

  // Storage write; contents are not reset because the head is gated when empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/my_dmux_4_way_stream.sv
// Buffered 4-way stream demultiplexer. One input stream is steered by sel
// into one of four channel FIFOs; each channel drains independently under
// its own ready, and counts the words it has delivered.
module my_dmux_4_way_stream
  import my_dmux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  sel_t             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic [CNT_W-1:0] count_c,
  output logic [CNT_W-1:0] count_d
);

  logic [3:0]       full;
  logic [3:0]       empty;
  logic [3:0]       push;
  logic [3:0]       pop;
  logic [WIDTH-1:0] head [4];
  logic [CNT_W-1:0] cnt  [4];

  // Ready only looks at the addressed FIFO's registered full flag.
  assign in_ready  = !full[sel];
  assign push      = (in_valid && in_ready) ? sel_onehot(sel) : 4'b0000;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    my_stream_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[i]),
      .push_data (in),
      .full      (full[i]),
      .pop       (pop[i]),
      .head      (head[i]),
      .empty     (empty[i])
    );
  end

  assign a = head[CH_A];
  assign b = head[CH_B];
  assign c = head[CH_C];
  assign d = head[CH_D];

  // Delivered-word counters, one per channel, wrapping silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pop[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign count_a = cnt[CH_A];
  assign count_b = cnt[CH_B];
  assign count_c = cnt[CH_C];
  assign count_d = cnt[CH_D];

endmodule

// File: tb/tb_my_dmux_4_way_stream.sv
// Bench for the 4-way stream demultiplexer: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_my_dmux_4_way_stream;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in;
  logic [1:0]       sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b, c, d;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [CNT_W-1:0] count_a, count_b, count_c, count_d;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-channel queue of accepted words plus pop counts.
  logic [WIDTH-1:0] mq [4][$];
  logic [CNT_W-1:0] mcnt [4];

  my_dmux_4_way_stream #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count_a   (count_a),
    .count_b   (count_b),
    .count_c   (count_c),
    .count_d   (count_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] head_obs(input int i);
    case (i)
      0:       return a;
      1:       return b;
      2:       return c;
      default: return d;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] count_obs(input int i);
    case (i)
      0:       return count_a;
      1:       return count_b;
      2:       return count_c;
      default: return count_d;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] model_head(input int i);
    if (mq[i].size() == 0) return '0;
    return mq[i][0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      mcnt[i] = '0;
    end
  endtask

  // Compare every output against the model with the current inputs applied.
  task automatic compare_all();
    logic [3:0] ev;
    for (int i = 0; i < 4; i++) ev[i] = (mq[i].size() != 0);
    check("out_valid", 32'(out_valid), 32'(ev));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("head%0d", i), 32'(head_obs(i)), 32'(model_head(i)));
      check($sformatf("count%0d", i), 32'(count_obs(i)), 32'(mcnt[i]));
    end
    check("in_ready", 32'(in_ready), 32'(mq[sel].size() < DEPTH));
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic step(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] dat,
                      input logic [3:0] ordy);
    logic acc;
    in_valid  = v;
    sel       = s;
    in        = dat;
    out_ready = ordy;
    #1;
    compare_all();
    acc = v && (mq[s].size() < DEPTH);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (mq[i].size() != 0 && ordy[i]) begin
        void'(mq[i].pop_front());
        mcnt[i] = mcnt[i] + CNT_W'(1);
      end
    end
    if (acc) mq[s].push_back(dat);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    reset     = 1'b1;
    in        = '0;
    sel       = '0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_count_a", 32'(count_a), 32'h0);
    check("rst_a", 32'(a), 32'h0);

    // Reset mid-stream discards the buffered word on c
    step(1'b1, 2'd2, 16'h1234, 4'b0000);
    check("mid_c_loaded", 32'(c), 32'h1234);
    do_reset();
    sel = 2'd2;
    #1;
    check("mid_out_valid", 32'(out_valid), 32'h0);
    check("mid_c", 32'(c), 32'h0);
    check("mid_count_c", 32'(count_c), 32'h0);
    check("mid_in_ready", 32'(in_ready), 32'h1);
    step(1'b0, 2'd0, '0, 4'b1111);

    // Basic routing with all consumers ready
    step(1'b1, 2'd0, 16'h8000, 4'b1111);
    check("route_a", 32'(a), 32'h8000);
    step(1'b1, 2'd1, 16'h0800, 4'b1111);
    check("route_b", 32'(b), 32'h0800);
    step(1'b1, 2'd2, 16'h0080, 4'b1111);
    check("route_c", 32'(c), 32'h0080);
    step(1'b1, 2'd3, 16'h0008, 4'b1111);
    check("route_d", 32'(d), 32'h0008);
    step(1'b0, 2'd0, '0, 4'b1111);
    #1;
    check("route_cnt_a", 32'(count_a), 32'h1);
    check("route_cnt_b", 32'(count_b), 32'h1);
    check("route_cnt_c", 32'(count_c), 32'h1);
    check("route_cnt_d", 32'(count_d), 32'h1);

    // Backpressure isolation on b
    step(1'b1, 2'd1, 16'h0B01, 4'b1101);
    step(1'b1, 2'd1, 16'h0B02, 4'b1101);
    in_valid = 1'b1; sel = 2'd1; out_ready = 4'b1101;
    #1;
    check("bp_b_blocked", 32'(in_ready), 32'h0);
    sel = 2'd0;
    #1;
    check("bp_a_open", 32'(in_ready), 32'h1);
    step(1'b1, 2'd1, 16'h0B03, 4'b1101);
    step(1'b1, 2'd0, 16'hAAAA, 4'b1101);
    check("bp_a_word", 32'(a), 32'hAAAA);
    check("bp_b_head", 32'(b), 32'h0B01);
    for (int k = 0; k < 3; k++) step(1'b0, 2'd0, '0, 4'b1111);

    // Simultaneous push/pop on d keeps occupancy and order
    step(1'b1, 2'd3, 16'h0001, 4'b0000);
    check("ord_d_first", 32'(d), 32'h0001);
    step(1'b1, 2'd3, 16'h0002, 4'b1000);
    check("ord_d_valid", 32'(out_valid[3]), 32'h1);
    check("ord_d_second", 32'(d), 32'h0002);
    step(1'b0, 2'd0, '0, 4'b1000);
    #1;
    check("ord_d_drained", 32'(out_valid[3]), 32'h0);

    // Full channel refuses a push even while popping
    step(1'b1, 2'd0, 16'hA001, 4'b0000);
    step(1'b1, 2'd0, 16'hA002, 4'b0000);
    in_valid = 1'b1; sel = 2'd0; out_ready = 4'b0001;
    #1;
    check("full_pop_ready0", 32'(in_ready), 32'h0);
    step(1'b1, 2'd0, 16'hA003, 4'b0001);
    check("full_next_ready1", 32'(in_ready), 32'h1);
    for (int k = 0; k < 3; k++) step(1'b0, 2'd0, '0, 4'b1111);

    // Counter wrap on b
    do_reset();
    step(1'b1, 2'd1, 16'(($urandom)), 4'b0010);
    for (int k = 0; k < (1 << CNT_W) - 1; k++) step(1'b1, 2'd1, 16'(($urandom)), 4'b0010);
    check("wrap_b_max", 32'(count_b), 32'((1 << CNT_W) - 1));
    step(1'b1, 2'd1, 16'(($urandom)), 4'b0010);
    check("wrap_b_zero", 32'(count_b), 32'h0);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
             16'($urandom), 4'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
